// File: rtl/exe_mem_stage_buf_pkg.sv
// rtl/exe_mem_stage_buf_pkg.sv - shared types and defaults for the EXE/MEM stage buffer
// Depth option: define EXE_MEM_SKID_EN for a two-entry (head + skid) buffer.
package exe_mem_stage_buf_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEST_W = 4;

  // Number of single-bit control fields at the top of every bundle.
  localparam int CTRL_W = 3;

  // Control bits, in the same MSB-first order as the flat bundle.
  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } ctrl_t;

  // Full bundle at default widths: {wb_en, mem_r_en, mem_w_en, alu_res, store_val, dest}.
  typedef struct packed {
    ctrl_t                      ctrl;
    logic [DEFAULT_DATA_W-1:0] alu_res;
    logic [DEFAULT_DATA_W-1:0] store_val;
    logic [DEFAULT_DEST_W-1:0] dest;
  } bundle_t;

  // Flat bundle width for arbitrary datapath/destination widths.
  function automatic int bundle_width(input int data_w, input int dest_w);
    return CTRL_W + 2 * data_w + dest_w;
  endfunction

endpackage

// File: rtl/exe_mem_stage_buf_pipe_bundle_reg.sv
// rtl/exe_mem_stage_buf_pipe_bundle_reg.sv - enable-loaded bundle register with async reset
module pipe_bundle_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next value: hold unless a load is requested.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end
  end

  // Entry storage; cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/exe_mem_stage_buf.sv
// rtl/exe_mem_stage_buf.sv - EXE to MEM pipeline buffer; EXE_MEM_SKID_EN adds a skid entry
module exe_mem_stage_buf
  import exe_mem_stage_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEST_W = DEFAULT_DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_store_val,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_store_val,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy
);

  localparam int BW = bundle_width(DATA_W, DEST_W);

  logic [BW-1:0] in_bundle;
  logic [BW-1:0] head_bundle;
  logic [BW-1:0] head_src;
  logic          head_load;
  logic          head_valid_q;
  logic          head_valid_d;
  logic          push;
  logic          pop;
  ctrl_t         head_ctrl;

  assign in_bundle = {in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_res, in_store_val, in_dest};

  // The head entry is always what MEM sees.
  pipe_bundle_reg #(.WIDTH(BW)) u_head (
    .clk  (clk),
    .rst  (rst),
    .load (head_load),
    .d    (head_src),
    .q    (head_bundle)
  );

`ifdef EXE_MEM_SKID_EN

  logic [BW-1:0] skid_bundle;
  logic          skid_load;
  logic          skid_valid_q;
  logic          skid_valid_d;
  logic          in_ready_q;
  logic          in_ready_d;

  // Second entry catches a push that arrives while the head is stalled.
  pipe_bundle_reg #(.WIDTH(BW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_bundle),
    .q    (skid_bundle)
  );

  // in_ready is registered so out_ready never reaches it combinationally.
  assign in_ready  = in_ready_q;
  assign push      = in_valid && in_ready_q && !flush;
  assign pop       = head_valid_q && out_ready;
  assign occupancy = {skid_valid_q, head_valid_q & ~skid_valid_q};

  // Entry movement: skid refills the head on pop; a push goes to head if it frees up, else to skid.
  always_comb begin
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    head_load    = 1'b0;
    skid_load    = 1'b0;
    head_src     = in_bundle;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      // in_ready was low, so no push can coincide with this move.
      head_load    = 1'b1;
      head_src     = skid_bundle;
      skid_valid_d = 1'b0;
    end else if (push && (!head_valid_q || pop)) begin
      head_load    = 1'b1;
      head_valid_d = 1'b1;
    end else if (push) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  // Valid flags and registered ready; ready comes out of reset high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

`else

  // Single entry: accept when empty or when the head drains this cycle.
  assign in_ready  = !head_valid_q || out_ready;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = head_valid_q && out_ready;
  assign head_load = push;
  assign head_src  = in_bundle;
  assign occupancy = {1'b0, head_valid_q};

  // Head valid flag: flush wins, a push (with or without pop) refills, a lone pop empties.
  always_comb begin
    head_valid_d = head_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
    end else if (push) begin
      head_valid_d = 1'b1;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end
  end

  // Head valid register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_q <= 1'b0;
    end else begin
      head_valid_q <= head_valid_d;
    end
  end

`endif

  // Outputs come straight from the head register; enables are masked by valid.
  assign head_ctrl     = head_bundle[BW-1 -: CTRL_W];
  assign out_valid     = head_valid_q;
  assign out_wb_en     = head_ctrl.wb_en    & head_valid_q;
  assign out_mem_r_en  = head_ctrl.mem_r_en & head_valid_q;
  assign out_mem_w_en  = head_ctrl.mem_w_en & head_valid_q;
  assign out_alu_res   = head_bundle[2*DATA_W+DEST_W-1 -: DATA_W];
  assign out_store_val = head_bundle[DATA_W+DEST_W-1 -: DATA_W];
  assign out_dest      = head_bundle[DEST_W-1:0];

endmodule

// File: tb/tb_exe_mem_stage_buf.sv
// tb/tb_exe_mem_stage_buf.sv - scoreboard bench for exe_mem_stage_buf (either EXE_MEM_SKID_EN build)
module tb_exe_mem_stage_buf;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct {
    logic          wb;
    logic          rd;
    logic          wr;
    logic [DW-1:0] alu;
    logic [DW-1:0] st;
    logic [RW-1:0] dest;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_wb_en = 1'b0;
  logic          in_mem_r_en = 1'b0;
  logic          in_mem_w_en = 1'b0;
  logic [DW-1:0] in_alu_res = '0;
  logic [DW-1:0] in_store_val = '0;
  logic [RW-1:0] in_dest = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_wb_en;
  logic          out_mem_r_en;
  logic          out_mem_w_en;
  logic [DW-1:0] out_alu_res;
  logic [DW-1:0] out_store_val;
  logic [RW-1:0] out_dest;
  logic [1:0]    occupancy;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  int   max_occ;

`ifdef EXE_MEM_SKID_EN
  localparam int FULL = 2;
`else
  localparam int FULL = 1;
`endif

  always #5 clk = ~clk;

  exe_mem_stage_buf #(.DATA_W(DW), .DEST_W(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_wb_en      (in_wb_en),
    .in_mem_r_en   (in_mem_r_en),
    .in_mem_w_en   (in_mem_w_en),
    .in_alu_res    (in_alu_res),
    .in_store_val  (in_store_val),
    .in_dest       (in_dest),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_wb_en     (out_wb_en),
    .out_mem_r_en  (out_mem_r_en),
    .out_mem_w_en  (out_mem_w_en),
    .out_alu_res   (out_alu_res),
    .out_store_val (out_store_val),
    .out_dest      (out_dest),
    .occupancy     (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wb, input logic rd, input logic wr,
                       input logic [DW-1:0] alu, input logic [RW-1:0] dest,
                       input logic ordy, input logic fl);
    in_valid     = v;
    in_wb_en     = wb;
    in_mem_r_en  = rd;
    in_mem_w_en  = wr;
    in_alu_res   = alu;
    in_store_val = ~alu;
    in_dest      = dest;
    out_ready    = ordy;
    flush        = fl;
  endtask

  // One cycle: check DUT against the model, update the model, advance past the edge.
  task automatic tick();
    logic exp_ready;
    logic do_push;
    logic do_pop;
    exp_t cur;
    #1;
`ifdef EXE_MEM_SKID_EN
    exp_ready = (sb.size() < 2);
`else
    exp_ready = (sb.size() == 0) || out_ready;
`endif
    check("occupancy", 64'(occupancy), 64'(sb.size()));
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_wb_en", 64'(out_wb_en), 64'(sb[0].wb));
      check("out_mem_r_en", 64'(out_mem_r_en), 64'(sb[0].rd));
      check("out_mem_w_en", 64'(out_mem_w_en), 64'(sb[0].wr));
      check("out_alu_res", 64'(out_alu_res), 64'(sb[0].alu));
      check("out_store_val", 64'(out_store_val), 64'(sb[0].st));
      check("out_dest", 64'(out_dest), 64'(sb[0].dest));
    end else begin
      check("idle_enables", 64'({out_wb_en, out_mem_r_en, out_mem_w_en}), 64'(0));
    end
    if (32'(occupancy) > max_occ) max_occ = 32'(occupancy);
    do_push = in_valid && exp_ready && !flush;
    do_pop  = (sb.size() != 0) && out_ready;
    cur.wb = in_wb_en; cur.rd = in_mem_r_en; cur.wr = in_mem_w_en;
    cur.alu = in_alu_res; cur.st = in_store_val; cur.dest = in_dest;
    if (flush) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_enables", 64'({out_wb_en, out_mem_r_en, out_mem_w_en}), 64'(0));
    check("rst_alu_res", 64'(out_alu_res), 64'(0));
    check("rst_dest", 64'(out_dest), 64'(0));
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'(1));

    // Stream three values back-to-back.
    max_occ = 0;
    drive(1, 1, 0, 0, 32'h11, 5'h01, 1, 0); tick();
    drive(1, 0, 1, 0, 32'h22, 5'h02, 1, 0); tick();
    drive(1, 0, 0, 1, 32'h33, 5'h03, 1, 0); tick();
    drive(0, 0, 0, 0, 32'h0, 5'h00, 1, 0); tick();
    tick();
    check("stream_max_occ", 64'(max_occ), 64'(1));

    // Stall with head 0xA, 0xB waiting upstream.
    drive(1, 1, 0, 0, 32'hA, 5'h0A, 0, 0); tick();
    drive(1, 0, 1, 0, 32'hB, 5'h0B, 0, 0);
    repeat (3) tick();
    #1;
    check("stall_head", 64'(out_alu_res), 64'(32'hA));
    check("stall_occ", 64'(occupancy), 64'(FULL));
    check("stall_in_ready", 64'(in_ready), 64'(0));
    drive(0, 0, 0, 0, 32'h0, 5'h00, 1, 0);
    repeat (3) tick();

    // Flush at full occupancy with a store pushing.
    drive(1, 0, 0, 1, 32'h44, 5'h04, 0, 0);
    repeat (FULL) tick();
    drive(1, 0, 0, 1, 32'h55, 5'h05, 0, 1); tick();
    drive(0, 0, 0, 0, 32'h0, 5'h00, 0, 0);
    check("flush_occ", 64'(occupancy), 64'(0));
    check("flush_mem_w_en", 64'(out_mem_w_en), 64'(0));
    tick();

    // Fill with 0x5 then 0x6, then drain in order.
    drive(1, 1, 1, 0, 32'h5, 5'h15, 0, 0); tick();
    drive(1, 0, 1, 1, 32'h6, 5'h16, 0, 0); tick();
    drive(0, 0, 0, 0, 32'h0, 5'h00, 1, 0);
    repeat (4) tick();

    // Full-width destination.
    drive(1, 1, 0, 1, 32'hDEAD_BEEF, 5'h1F, 0, 0); tick();
    drive(0, 0, 0, 0, 32'h0, 5'h00, 0, 0);
    check("dest_full_width", 64'(out_dest), 64'(5'h1F));
    drive(0, 0, 0, 0, 32'h0, 5'h00, 1, 0); tick(); tick();

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, 5'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      tick();
    end
    drive(0, 0, 0, 0, 32'h0, 5'h00, 1, 0);
    repeat (3) tick();

    // Asynchronous reset mid-cycle with a held write-back entry.
    drive(1, 1, 0, 0, 32'h77, 5'h07, 0, 0); tick();
    drive(0, 0, 0, 0, 32'h0, 5'h00, 0, 0);
    check("pre_rst_wb_en", 64'(out_wb_en), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_wb_en", 64'(out_wb_en), 64'(0));
    check("async_rst_occ", 64'(occupancy), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem_stage_buf.md
EXE_MEM_STAGE_BUF -- requirements
Module: exe_mem_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of ALU result and store value.
REQ-002 SHALL have parameter DEST_W, default 4: width of destination register index.
REQ-003 SHALL have port clk  input  1  clock, rising edge active.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream (EXE) bundle present.
REQ-007 SHALL have port in_ready  output  1  buffer accepts bundle this cycle.
REQ-008 SHALL have ports in_wb_en, in_mem_r_en, in_mem_w_en  input  1 each  control bits.
REQ-009 SHALL have ports in_alu_res, in_store_val  input  DATA_W each  datapath values.
REQ-010 SHALL have port in_dest  input  DEST_W  writeback register index.
REQ-011 SHALL have port out_valid  output  1  head bundle present toward MEM.
REQ-012 SHALL have port out_ready  input  1  MEM consumes head this cycle.
REQ-013 SHALL have ports out_wb_en, out_mem_r_en, out_mem_w_en, out_alu_res, out_store_val, out_dest  output  matching input widths  head bundle.
REQ-014 SHALL have port occupancy  output  2  number of valid entries held.

Function
REQ-015 Bundle SHALL be {wb_en, mem_r_en, mem_w_en, alu_res, store_val, dest}; entries SHALL leave in arrival order.
REQ-016 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready.
REQ-017 out_wb_en, out_mem_r_en, out_mem_w_en SHALL be ANDed with out_valid; no enable SHALL be asserted while out_valid=0.
REQ-018 out_valid SHALL equal (occupancy != 0); outputs SHALL be driven directly from the head register, with no combinational path from in_* to out_*.
REQ-019 Latency SHALL be one cycle: a bundle pushed at edge N is visible on out_* after edge N.
REQ-020 flush SHALL set occupancy to 0 at the next edge, overriding any simultaneous push or pop; data registers need not clear.
REQ-021 Simultaneous push and pop at occupancy 1 SHALL replace the head and keep occupancy at 1.
REQ-022 out_* SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-023 On rst, occupancy SHALL be 0, out_valid 0, all control outputs 0, and all data registers 0.
REQ-024 rst asserted mid-transfer SHALL discard all held entries immediately, without waiting for a clock edge.
REQ-025 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-026 Macro EXE_MEM_SKID_EN SHALL select buffering depth.
REQ-027 With EXE_MEM_SKID_EN defined: the block SHALL have two entries (head plus skid); in_ready SHALL be a register equal to (skid empty) with no combinational path from out_ready; a push at occupancy 1 without a pop SHALL fill the skid; a pop at occupancy 2 SHALL move the skid into the head; occupancy SHALL range 0..2; a push at occupancy 2 SHALL be impossible.
REQ-028 Without EXE_MEM_SKID_EN: the block SHALL have one entry; in_ready SHALL be !out_valid || out_ready, computed combinationally; occupancy SHALL range 0..1; bit 1 of occupancy SHALL be 0.

Structure
REQ-029 A shared package SHALL hold the bundle struct type and the localparams for the default DATA_W and DEST_W.
REQ-030 One sub-module, pipe_bundle_reg, SHALL hold a single entry: it SHALL be an enable-loaded bundle register with asynchronous reset, instantiated once, or twice with EXE_MEM_SKID_EN defined.

Verification
REQ-031 Stream: push alu_res 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> the same values appear on out_alu_res one cycle later, back-to-back, and occupancy never exceeds 1.
REQ-032 Stall: push 0xA, hold out_ready=0 for 3 cycles, keep in_valid=1 with 0xB -> 0xA stays stable; with skid, 0xB is held, occupancy=2, and in_ready=0; without skid, in_ready=0 and occupancy=1.
REQ-033 Flush: occupancy=2, flush=1 with in_valid=1 and in_mem_w_en=1 -> next cycle occupancy=0 and out_mem_w_en=0.
REQ-034 Async reset: assert rst between edges while occupancy=1 and out_wb_en=1 -> out_valid=0 and out_wb_en=0 before the next edge.
REQ-035 Skid drain: hold occupancy=2 (head 0x5, skid 0x6), then set out_ready=1 -> 0x5 then 0x6 appear on out_alu_res, in_ready rises one cycle after the first pop, and the order is preserved.
REQ-036 Dest width: with DEST_W=5, push dest 5'h1F -> out_dest=5'h1F, with no truncation.
